// File: rtl/riscv_arb_mux.sv
// riscv_arb_mux: N-input arbitrated, registered multiplexer with valid/ready
// handshakes on every input channel and on the single output.
// A round-robin arbiter picks the channel; the chosen word is captured in a
// one-entry output register that can drain and reload in the same cycle.
// Optional build macro RISCV_ARB_MUX_FIXED_PRIO_EN: replaces the round-robin
// arbiter with a fixed-priority one (lowest index wins, no pointer state).

`ifndef XLEN
`define XLEN 32
`endif

module riscv_arb_mux #(
  parameter int unsigned N_MUX_IN = 2,
  parameter int unsigned DATA_W   = `XLEN
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [N_MUX_IN-1:0]          i_mux_valid,
  output logic [N_MUX_IN-1:0]          o_mux_ready,
  input  logic [N_MUX_IN*DATA_W-1:0]   i_mux_concat_data,
  output logic                         o_mux_valid,
  input  logic                         i_mux_ready,
  output logic [DATA_W-1:0]            o_mux_data,
  output logic [$clog2(N_MUX_IN)-1:0]  o_mux_sel
);

  localparam int unsigned SEL_W = $clog2(N_MUX_IN);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_MUX_IN - 1);

  logic              accept_c;
  logic              xfer_c;
  logic              grant_vld_c;
  logic [SEL_W-1:0]  grant_idx_c;
  logic [DATA_W-1:0] grant_data_c;

  // Index of the lowest set bit of a request vector (0 when empty).
  function automatic logic [SEL_W-1:0] lowest_idx(input logic [N_MUX_IN-1:0] req);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = int'(N_MUX_IN) - 1; i >= 0; i--) begin
      if (req[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

`ifdef RISCV_ARB_MUX_FIXED_PRIO_EN

  // Fixed priority: the lowest-indexed valid channel always wins.
  always_comb begin
    grant_vld_c = |i_mux_valid;
    grant_idx_c = lowest_idx(i_mux_valid);
  end

`else

  logic [SEL_W-1:0]    prio_ptr;
  logic [N_MUX_IN-1:0] hi_mask_c;
  logic [N_MUX_IN-1:0] hi_req_c;

  // Round robin: prefer requests at or above the pointer, else wrap to the bottom.
  always_comb begin
    hi_mask_c   = ~((N_MUX_IN'(1) << prio_ptr) - N_MUX_IN'(1));
    hi_req_c    = i_mux_valid & hi_mask_c;
    grant_vld_c = |i_mux_valid;
    if (|hi_req_c) begin
      grant_idx_c = lowest_idx(hi_req_c);
    end else begin
      grant_idx_c = lowest_idx(i_mux_valid);
    end
  end

  // Priority pointer moves to one past the last granted channel.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prio_ptr <= '0;
    end else if (xfer_c) begin
      prio_ptr <= (grant_idx_c == LAST_IDX) ? '0 : grant_idx_c + SEL_W'(1);
    end
  end

`endif

  // Handshake: load when the register is empty or draining this cycle.
  always_comb begin
    accept_c = ~o_mux_valid | i_mux_ready;
    xfer_c   = accept_c & grant_vld_c & ~i_rst;
  end

  // One-hot accept back to the granted channel only.
  always_comb begin
    o_mux_ready = '0;
    if (xfer_c) begin
      o_mux_ready[grant_idx_c] = 1'b1;
    end
  end

  // Select the granted channel's data word.
  always_comb begin
    grant_data_c = '0;
    for (int i = 0; i < int'(N_MUX_IN); i++) begin
      if (grant_idx_c == SEL_W'(i)) begin
        grant_data_c = i_mux_concat_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // One-entry output register; data and sel hold when nothing new is loaded.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_mux_valid <= 1'b0;
      o_mux_data  <= '0;
      o_mux_sel   <= '0;
    end else if (xfer_c) begin
      o_mux_valid <= 1'b1;
      o_mux_data  <= grant_data_c;
      o_mux_sel   <= grant_idx_c;
    end else if (i_mux_ready) begin
      o_mux_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_riscv_arb_mux.sv
// Self-checking bench for riscv_arb_mux (N=4, DATA_W=32): directed scenarios
// with literal expectations plus randomized traffic against a behavioural model.

`timescale 1ns/1ps

module tb_riscv_arb_mux;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   vin;
  logic [N-1:0]   rdy_out;
  logic [N*W-1:0] din;
  logic           ov;
  logic           ir;
  logic [W-1:0]   od;
  logic [1:0]     os;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: what the output register and arbiter pointer must hold.
  bit          m_known = 1'b0;
  bit          m_v;
  logic [31:0] m_d;
  int          m_sel;
  int          m_ptr;

  riscv_arb_mux #(.N_MUX_IN(N), .DATA_W(W)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_mux_valid       (vin),
    .o_mux_ready       (rdy_out),
    .i_mux_concat_data (din),
    .o_mux_valid       (ov),
    .i_mux_ready       (ir),
    .o_mux_data        (od),
    .o_mux_sel         (os)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner among valid channels, or -1 when nobody requests.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
`ifdef RISCV_ARB_MUX_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (v[i]) return i;
`else
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
`endif
    return -1;
  endfunction

  function automatic logic [W-1:0] chan_data(input int c);
    return din[c*W +: W];
  endfunction

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    int          g;
    bit          acc;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    g       = pick(vin, m_ptr);
    acc     = !m_v || ir;
    exp_rdy = '0;
    if (!rst && acc && g >= 0) exp_rdy[g] = 1'b1;
    chk("ready", 64'(rdy_out), 64'(exp_rdy));
    if (m_known) begin
      chk("valid", 64'(ov), 64'(m_v));
      chk("data",  64'(od), 64'(m_d));
      chk("sel",   64'(os), 64'(m_sel));
    end
    @(posedge clk);
    if (rst) begin
      m_known = 1'b1;
      m_v = 1'b0; m_d = '0; m_sel = 0; m_ptr = 0;
    end else if (acc && g >= 0) begin
      m_v = 1'b1; m_d = chan_data(g); m_sel = g; m_ptr = (g + 1) % N;
    end else if (m_v && ir) begin
      m_v = 1'b0;
    end
    #1;
  endtask

  task automatic set_chan(input int c, input logic [W-1:0] d);
    din[c*W +: W] = d;
  endtask

  initial begin
    logic [31:0] exp_w;
    rst = 1'b1; vin = '1; ir = 1'b1; din = '0;
    for (int c = 0; c < N; c++) set_chan(c, 32'h1000 + 32'(c));

    // Reset held two cycles with every channel requesting.
    step();
    #2 chk("rst_ready", 64'(rdy_out), 64'h0);
    step();
    chk("rst_valid", 64'(ov), 64'h0);
    chk("rst_data",  64'(od), 64'h0);
    chk("rst_sel",   64'(os), 64'h0);

    // Single channel 2.
    rst = 1'b0; vin = 4'b0100; set_chan(2, 32'hDEADBEEF);
    #2 chk("single_ready", 64'(rdy_out), 64'h4);
    step();
    chk("single_valid", 64'(ov), 64'h1);
    chk("single_data",  64'(od), 64'hDEADBEEF);
    chk("single_sel",   64'(os), 64'h2);

    // Round robin from a fresh pointer.
    rst = 1'b1; vin = '0; step();
    rst = 1'b0; vin = '1;
    for (int c = 0; c < N; c++) set_chan(c, 32'h1000 + 32'(c));
    for (int k = 0; k < 5; k++) begin
      step();
`ifdef RISCV_ARB_MUX_FIXED_PRIO_EN
      exp_w = 32'h1000;
`else
      exp_w = 32'h1000 + 32'(k % N);
`endif
      chk("rr_data", 64'(od), 64'(exp_w));
    end

    // Backpressure: hold 0xA5A5A5A5 from channel 1, channels 0 and 3 waiting.
    rst = 1'b1; vin = '0; step();
    rst = 1'b0; vin = 4'b0010; set_chan(1, 32'hA5A5A5A5);
    set_chan(0, 32'hC0); set_chan(3, 32'hC3);
    step();
    vin = 4'b1001; ir = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2 chk("bp_ready", 64'(rdy_out), 64'h0);
      step();
      chk("bp_data", 64'(od), 64'hA5A5A5A5);
      chk("bp_sel",  64'(os), 64'h1);
    end
    ir = 1'b1;
    step();
`ifdef RISCV_ARB_MUX_FIXED_PRIO_EN
    chk("bp_first", 64'(od), 64'hC0);
`else
    chk("bp_first", 64'(od), 64'hC3);
`endif
    step();
    chk("bp_second", 64'(od), 64'hC0);

    // Wrap-around: grant 3, then lone channel 1, then channels 0 and 2.
    set_chan(1, 32'hB1); set_chan(2, 32'hB2); set_chan(0, 32'hB0);
    vin = 4'b1000; step();
    vin = 4'b0010; step();
    chk("wrap_lone", 64'(os), 64'h1);
    vin = 4'b0101; step();
`ifdef RISCV_ARB_MUX_FIXED_PRIO_EN
    chk("wrap_a", 64'(os), 64'h0);
`else
    chk("wrap_a", 64'(os), 64'h2);
`endif
    step();
    chk("wrap_b", 64'(os), 64'h0);

    // Reset during a stall discards the held word.
    vin = 4'b0001; set_chan(0, 32'h5555AAAA); step();
    vin = '0; ir = 1'b0; step();
    rst = 1'b1; step();
    chk("rststall_valid", 64'(ov), 64'h0);
    chk("rststall_data",  64'(od), 64'h0);
    rst = 1'b0; ir = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("rststall_gone", 64'(ov), 64'h0);
    end

    // Randomized traffic, all checked by the model in step().
    for (int k = 0; k < 400; k++) begin
      vin = N'($urandom);
      ir  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) == 0);
      for (int c = 0; c < N; c++) set_chan(c, $urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
